// File: rtl/lsu_ctrl.sv
// Load/store sequencer between RV32I execute and a req/ack + rvalid data memory.
// Optional watchdog on REQ/WAIT enabled by defining LSU_TIMEOUT_EN (limit TIMEOUT_CYC).
module lsu_ctrl #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ld_en,
    input  logic        i_st_en,
    input  logic [2:0]  i_type_access,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_st_data,
    output logic        o_stall,
    output logic [31:0] o_ld_data,
    output logic        o_ld_vld,
    output logic        o_misalign,
    output logic        o_timeout,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    input  logic        i_mem_ack,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state, next_state;
    logic        access;
    logic        bad_acc;
    logic [3:0]  acc_mask;
    logic [31:0] acc_wdata;
    logic [1:0]  addr_q;
    logic [2:0]  f3_q;
    logic        st_q;
    logic        tmo_hit;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign access  = i_ld_en | i_st_en;
    assign o_stall = ((state == IDLE) & access) | (state == REQ) | (state == WAIT);

    // Reserved funct3 codes and unsigned stores are rejected regardless of address.
    always_comb begin
        bad_acc = 1'b1;
        case (i_type_access)
            3'b000:  bad_acc = 1'b0;
            3'b001:  bad_acc = i_addr[0];
            3'b010:  bad_acc = |i_addr[1:0];
            3'b100:  bad_acc = i_st_en;
            3'b101:  bad_acc = i_st_en | i_addr[0];
            default: bad_acc = 1'b1;
        endcase
    end

    always_comb begin
        acc_mask  = 4'b1111;
        acc_wdata = i_st_data;
        case (i_type_access[1:0])
            2'b00: begin
                acc_mask  = 4'b0001 << i_addr[1:0];
                acc_wdata = {4{i_st_data[7:0]}};
            end
            2'b01: begin
                acc_mask  = i_addr[1] ? 4'b1100 : 4'b0011;
                acc_wdata = {2{i_st_data[15:0]}};
            end
            default: begin
                acc_mask  = 4'b1111;
                acc_wdata = i_st_data;
            end
        endcase
    end

    assign ld_byte = 8'(i_mem_rdata >> {addr_q, 3'b000});
    assign ld_half = addr_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

    always_comb begin
        ld_ext = i_mem_rdata;
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = i_mem_rdata;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (access) next_state = bad_acc ? DONE : REQ;
            REQ: begin
                if (i_mem_ack)    next_state = st_q ? DONE : WAIT;
                else if (tmo_hit) next_state = DONE;
            end
            WAIT: if (i_mem_rvalid || tmo_hit) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Memory-side outputs are registered and only move on state transitions.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            addr_q      <= 2'b00;
            f3_q        <= 3'b000;
            st_q        <= 1'b0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= 32'h0;
            o_mem_wdata <= 32'h0;
            o_mem_bmask <= 4'b0000;
            o_ld_data   <= 32'h0;
            o_ld_vld    <= 1'b0;
            o_misalign  <= 1'b0;
        end else begin
            o_ld_vld   <= 1'b0;
            o_misalign <= 1'b0;
            case (state)
                IDLE: if (access) begin
                    addr_q <= i_addr[1:0];
                    f3_q   <= i_type_access;
                    st_q   <= i_st_en;
                    if (bad_acc) begin
                        o_misalign <= 1'b1;
                        o_ld_data  <= 32'h0;
                    end else begin
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= i_st_en;
                        o_mem_addr  <= {i_addr[31:2], 2'b00};
                        o_mem_wdata <= acc_wdata;
                        o_mem_bmask <= acc_mask;
                    end
                end
                REQ: if (i_mem_ack || tmo_hit) begin
                    o_mem_req <= 1'b0;
                    o_mem_we  <= 1'b0;
                    if (!i_mem_ack) o_ld_data <= 32'h0;
                end
                WAIT: begin
                    if (i_mem_rvalid) begin
                        o_ld_data <= ld_ext;
                        o_ld_vld  <= 1'b1;
                    end else if (tmo_hit) begin
                        o_ld_data <= 32'h0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LSU_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        tmo_q;

    assign tmo_hit   = ((state == REQ) || (state == WAIT)) && (tmo_cnt == 16'(TIMEOUT_CYC - 1));
    assign o_timeout = tmo_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            tmo_cnt <= 16'h0;
            tmo_q   <= 1'b0;
        end else begin
            tmo_q <= tmo_hit && (((state == REQ) && !i_mem_ack) || ((state == WAIT) && !i_mem_rvalid));
            if ((state == IDLE) || ((state == REQ) && (next_state == WAIT)))
                tmo_cnt <= 16'h0;
            else if ((state == REQ) || (state == WAIT))
                tmo_cnt <= tmo_cnt + 16'h1;
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl; timeout scenario only when LSU_TIMEOUT_EN is defined.
module tb_lsu_ctrl;

`ifdef LSU_TIMEOUT_EN
    localparam int TB_TMO = 4;
`else
    localparam int TB_TMO = 255;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_ld_en, i_st_en;
    logic [2:0]  i_type_access;
    logic [31:0] i_addr, i_st_data;
    logic        o_stall;
    logic [31:0] o_ld_data;
    logic        o_ld_vld, o_misalign, o_timeout;
    logic        o_mem_req, o_mem_we;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        i_mem_ack, i_mem_rvalid;
    logic [31:0] i_mem_rdata;

    int vec = 0;
    int errs = 0;

    lsu_ctrl #(.TIMEOUT_CYC(TB_TMO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ld_en(i_ld_en), .i_st_en(i_st_en),
        .i_type_access(i_type_access), .i_addr(i_addr), .i_st_data(i_st_data),
        .o_stall(o_stall), .o_ld_data(o_ld_data), .o_ld_vld(o_ld_vld),
        .o_misalign(o_misalign), .o_timeout(o_timeout), .o_mem_req(o_mem_req),
        .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .o_mem_bmask(o_mem_bmask), .i_mem_ack(i_mem_ack), .i_mem_rvalid(i_mem_rvalid),
        .i_mem_rdata(i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clr_in();
        i_ld_en = 0; i_st_en = 0; i_type_access = 3'b000; i_addr = 32'h0;
        i_st_data = 32'h0; i_mem_ack = 0; i_mem_rvalid = 0; i_mem_rdata = 32'h0;
    endtask

    task automatic test_reset();
        i_rst_n = 0;
        clr_in();
        tick(); tick();
        vec++; if (o_mem_req !== 1'b0) begin errs++; $display("FAIL rst_req got %b want 0", o_mem_req); end
        vec++; if (o_stall !== 1'b0) begin errs++; $display("FAIL rst_stall got %b want 0", o_stall); end
        vec++; if ({o_ld_vld, o_misalign, o_timeout, o_mem_we} !== 4'b0) begin errs++; $display("FAIL rst_flags got %b want 0000", {o_ld_vld, o_misalign, o_timeout, o_mem_we}); end
        vec++; if ({o_mem_addr, o_mem_wdata, o_ld_data} !== 96'h0) begin errs++; $display("FAIL rst_data got %h/%h/%h want 0", o_mem_addr, o_mem_wdata, o_ld_data); end
        vec++; if (o_mem_bmask !== 4'b0000) begin errs++; $display("FAIL rst_bmask got %b want 0000", o_mem_bmask); end
        i_rst_n = 1;
        tick();
    endtask

    // Zero-wait store: ack in the first REQ cycle, DONE next.
    task automatic test_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                              input logic [31:0] exp_addr, input logic [31:0] exp_wd, input logic [3:0] exp_bm);
        i_st_en = 1; i_type_access = f3; i_addr = addr; i_st_data = data; i_mem_ack = 1;
        #1;
        vec++; if (o_stall !== 1'b1) begin errs++; $display("FAIL st_stall_c0 got %b want 1", o_stall); end
        tick();
        i_st_en = 0;
        #1;
        vec++; if ({o_mem_req, o_mem_we, o_stall} !== 3'b111) begin errs++; $display("FAIL st_req_c1 got %b want 111", {o_mem_req, o_mem_we, o_stall}); end
        vec++; if (o_mem_addr !== exp_addr) begin errs++; $display("FAIL st_addr got %h want %h", o_mem_addr, exp_addr); end
        vec++; if (o_mem_wdata !== exp_wd) begin errs++; $display("FAIL st_wdata got %h want %h", o_mem_wdata, exp_wd); end
        vec++; if (o_mem_bmask !== exp_bm) begin errs++; $display("FAIL st_bmask got %b want %b", o_mem_bmask, exp_bm); end
        tick();
        i_mem_ack = 0;
        vec++; if ({o_mem_req, o_stall, o_ld_vld, o_misalign} !== 4'b0000) begin errs++; $display("FAIL st_done got %b want 0000", {o_mem_req, o_stall, o_ld_vld, o_misalign}); end
        tick();
    endtask

    // Load with ack after ack_dly REQ cycles and rvalid rv_dly cycles into WAIT.
    task automatic test_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                             input int ack_dly, input int rv_dly, input logic [3:0] exp_bm,
                             input logic [31:0] exp_ld);
        i_ld_en = 1; i_type_access = f3; i_addr = addr;
        tick();
        i_ld_en = 0;
        for (int c = 0; c < ack_dly; c++) begin
            i_mem_ack = (c == ack_dly - 1);
            // rvalid coinciding with ack must be ignored
            i_mem_rvalid = 1; i_mem_rdata = 32'h5A5A5A5A;
            #1;
            vec++; if ({o_mem_req, o_mem_we, o_stall} !== 3'b101) begin errs++; $display("FAIL ld_req c%0d got %b want 101", c, {o_mem_req, o_mem_we, o_stall}); end
            vec++; if (o_mem_addr !== {addr[31:2], 2'b00} || o_mem_bmask !== exp_bm) begin errs++; $display("FAIL ld_addr c%0d got %h/%b want %h/%b", c, o_mem_addr, o_mem_bmask, {addr[31:2], 2'b00}, exp_bm); end
            tick();
        end
        i_mem_ack = 0; i_mem_rvalid = 0;
        for (int c = 0; c < rv_dly; c++) begin
            vec++; if ({o_mem_req, o_stall, o_ld_vld} !== 3'b010) begin errs++; $display("FAIL ld_wait c%0d got %b want 010", c, {o_mem_req, o_stall, o_ld_vld}); end
            tick();
        end
        i_mem_rvalid = 1; i_mem_rdata = rdata;
        tick();
        i_mem_rvalid = 0;
        vec++; if ({o_ld_vld, o_stall, o_misalign} !== 3'b100) begin errs++; $display("FAIL ld_vld got %b want 100", {o_ld_vld, o_stall, o_misalign}); end
        vec++; if (o_ld_data !== exp_ld) begin errs++; $display("FAIL ld_data got %h want %h", o_ld_data, exp_ld); end
        tick();
        vec++; if (o_ld_vld !== 1'b0) begin errs++; $display("FAIL ld_vld_pulse got %b want 0", o_ld_vld); end
    endtask

    task automatic test_misalign(input logic st, input logic [2:0] f3, input logic [31:0] addr);
        i_ld_en = !st; i_st_en = st; i_type_access = f3; i_addr = addr; i_st_data = 32'hFFFF_FFFF;
        #1;
        vec++; if ({o_stall, o_mem_req} !== 2'b10) begin errs++; $display("FAIL mis_c0 f3=%b got %b want 10", f3, {o_stall, o_mem_req}); end
        tick();
        i_ld_en = 0; i_st_en = 0;
        vec++; if ({o_misalign, o_mem_req, o_stall, o_ld_vld} !== 4'b1000) begin errs++; $display("FAIL mis_c1 f3=%b got %b want 1000", f3, {o_misalign, o_mem_req, o_stall, o_ld_vld}); end
        vec++; if (o_ld_data !== 32'h0) begin errs++; $display("FAIL mis_ld_data got %h want 0", o_ld_data); end
        tick();
        vec++; if ({o_misalign, o_mem_req} !== 2'b00) begin errs++; $display("FAIL mis_c2 got %b want 00", {o_misalign, o_mem_req}); end
    endtask

    task automatic test_reset_in_wait();
        i_ld_en = 1; i_type_access = 3'b010; i_addr = 32'h7000;
        tick();
        i_ld_en = 0; i_mem_ack = 1;
        tick();
        i_mem_ack = 0; i_rst_n = 0;
        tick();
        i_rst_n = 1; i_mem_rvalid = 1; i_mem_rdata = 32'hCAFEF00D; i_mem_ack = 1;
        #1;
        vec++; if ({o_mem_req, o_stall, o_ld_vld, o_mem_we} !== 4'b0000) begin errs++; $display("FAIL rstw_flags got %b want 0000", {o_mem_req, o_stall, o_ld_vld, o_mem_we}); end
        vec++; if ({o_mem_addr, o_mem_wdata, o_ld_data, o_mem_bmask} !== 100'h0) begin errs++; $display("FAIL rstw_data got %h/%h/%h/%b want 0", o_mem_addr, o_mem_wdata, o_ld_data, o_mem_bmask); end
        tick();
        vec++; if ({o_mem_req, o_stall, o_ld_vld, o_ld_data} !== 35'h0) begin errs++; $display("FAIL rstw_late got %b/%h want 0", {o_mem_req, o_stall, o_ld_vld}, o_ld_data); end
        clr_in();
        tick();
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        i_ld_en = 1; i_type_access = 3'b010; i_addr = 32'h8000;
        tick();
        i_ld_en = 0;
        for (int c = 1; c <= 4; c++) begin
            vec++; if ({o_mem_req, o_timeout} !== 2'b10) begin errs++; $display("FAIL tmo_c%0d got %b want 10", c, {o_mem_req, o_timeout}); end
            tick();
        end
        vec++; if ({o_timeout, o_mem_req, o_stall, o_ld_vld} !== 4'b1000) begin errs++; $display("FAIL tmo_c5 got %b want 1000", {o_timeout, o_mem_req, o_stall, o_ld_vld}); end
        vec++; if (o_ld_data !== 32'h0) begin errs++; $display("FAIL tmo_ld_data got %h want 0", o_ld_data); end
        tick();
        vec++; if ({o_timeout, o_mem_req} !== 2'b00) begin errs++; $display("FAIL tmo_c6 got %b want 00", {o_timeout, o_mem_req}); end
    endtask
`else
    task automatic test_no_timeout();
        i_ld_en = 1; i_type_access = 3'b010; i_addr = 32'h8000;
        tick();
        i_ld_en = 0;
        for (int c = 0; c < 300; c++) tick();
        vec++; if ({o_mem_req, o_stall, o_timeout} !== 3'b110) begin errs++; $display("FAIL notmo got %b want 110", {o_mem_req, o_stall, o_timeout}); end
        i_mem_ack = 1;
        tick();
        i_mem_ack = 0; i_mem_rvalid = 1; i_mem_rdata = 32'h0BAD_F00D;
        tick();
        i_mem_rvalid = 0;
        vec++; if ({o_ld_vld, o_timeout} !== 2'b10 || o_ld_data !== 32'h0BADF00D) begin errs++; $display("FAIL notmo_done got %b/%h want 10/0badf00d", {o_ld_vld, o_timeout}, o_ld_data); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_store(3'b000, 32'h1003, 32'h0000_00A5, 32'h1000, 32'hA5A5A5A5, 4'b1000);
        test_store(3'b001, 32'h6002, 32'hABCD_1234, 32'h6000, 32'h12341234, 4'b1100);
        test_store(3'b010, 32'h6004, 32'h1234_5678, 32'h6004, 32'h12345678, 4'b1111);
        test_load(3'b000, 32'h2002, 32'h0080_0000, 1, 2, 4'b0100, 32'hFFFFFF80);
        test_load(3'b100, 32'h2002, 32'h0080_0000, 1, 2, 4'b0100, 32'h00000080);
        test_load(3'b101, 32'h4002, 32'hBEEF_1234, 3, 0, 4'b1100, 32'h0000BEEF);
        test_load(3'b001, 32'h4000, 32'h0000_8001, 1, 0, 4'b0011, 32'hFFFF8001);
        test_load(3'b010, 32'h5000, 32'hDEAD_BEEF, 1, 1, 4'b1111, 32'hDEADBEEF);
        test_misalign(1'b0, 3'b010, 32'h3002);
        test_misalign(1'b0, 3'b011, 32'h3000);
        test_misalign(1'b1, 3'b001, 32'h1001);
        test_misalign(1'b1, 3'b100, 32'h1000);
        test_misalign(1'b0, 3'b111, 32'h1000);
        test_reset_in_wait();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer between the RV32I decode/execute stage and a variable-latency data memory. It accepts one load or store per instruction from the control decoder (funct3 access type, ALU address, rs2 data) and checks alignment. It then runs a req/ack + rvalid handshake to memory, stalling the core until the access completes, and returns aligned, sign/zero-extended load data for writeback.

## Interface
- TIMEOUT_CYC, 255: cycles allowed in REQ or WAIT before abort; used only when LSU_TIMEOUT_EN is defined; legal range 1..65535.

- i_clk  in  1  clock, all state updates on rising edge
- i_rst_n  in  1  synchronous, active-low reset
- i_ld_en  in  1  current instruction is a load
- i_st_en  in  1  current instruction is a store; i_ld_en & i_st_en never both high
- i_type_access  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_addr  in  32  effective byte address from ALU
- i_st_data  in  32  rs2 store data
- o_stall  out  1  hold PC, pipeline and register-file write
- o_ld_data  out  32  aligned and extended load result
- o_ld_vld  out  1  one-cycle pulse: o_ld_data valid for writeback
- o_misalign  out  1  one-cycle pulse: misaligned or illegal access, no memory traffic issued
- o_timeout  out  1  one-cycle pulse: access aborted by watchdog
- o_mem_req  out  1  memory request
- o_mem_we  out  1  1 = write, 0 = read; valid while o_mem_req
- o_mem_addr  out  32  word address, bits [1:0] always 0
- o_mem_wdata  out  32  lane-replicated store data
- o_mem_bmask  out  4  byte-lane enables
- i_mem_ack  in  1  request accepted, sampled only while o_mem_req = 1
- i_mem_rvalid  in  1  read data valid, sampled only in WAIT
- i_mem_rdata  in  32  read data word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, no access requested: stay in IDLE.
- IDLE with i_ld_en|i_st_en:
  - Latch address, funct3, direction and store data.
  - Legal and aligned access: go to REQ.
  - Otherwise: go to DONE with the misalign flag set.
- Alignment rules:
  - H/HU require addr[0]=0.
  - W requires addr[1:0]=00.
  - funct3 011, 110, 111 are illegal for any address.
  - Stores with funct3 1xx are illegal.
- REQ: o_mem_req=1 and held stable until i_mem_ack.
  - On ack, a store goes to DONE.
  - On ack, a load goes to WAIT.
- WAIT: on i_mem_rvalid, capture i_mem_rdata and go to DONE. rvalid in the same cycle as ack is not sampled; it is sampled from the next cycle.
- DONE: exit to IDLE unconditionally.
  - o_ld_vld pulses for loads that were neither aborted nor misaligned.
  - o_misalign or o_timeout pulses as flagged.
  - i_ld_en/i_st_en are ignored in DONE.
- o_stall = (IDLE & (i_ld_en|i_st_en)) | REQ | WAIT. It is low in DONE, so the core advances at the end of DONE.
- Byte masks:
  - B: 0001 shifted left by addr[1:0].
  - H: 0011 if addr[1]=0, else 1100.
  - W: 1111.
  - Masks apply to reads and writes.
- Store data: B = {4{rs2[7:0]}}, H = {2{rs2[15:0]}}, W = rs2.
- Load extraction selects the lane by the latched addr[1:0]:
  - B sign-extends bit 7; BU zero-extends.
  - H sign-extends bit 15; HU zero-extends.
  - W is passed through.
- o_ld_data is 0 in DONE after a misalign or timeout.

## Timing
- Reset values: state IDLE; o_mem_req, o_mem_we, o_ld_vld, o_misalign, o_timeout = 0; o_mem_addr, o_mem_wdata, o_ld_data = 0; o_mem_bmask = 0000.
- Best-case store, access seen at cycle 0: req at cycle 1 with ack at cycle 1, DONE at cycle 2. Stall is high for cycles 0–1.
- Best-case load: req/ack at cycle 1, rvalid at cycle 2, DONE at cycle 3 with o_ld_vld. Stall is high for cycles 0–2.
- Misaligned access: DONE at cycle 1, o_misalign pulses at cycle 1, o_mem_req never asserted.
- Reset asserted mid-operation: FSM returns to IDLE at the next edge, o_mem_req drops, and late ack/rvalid are ignored.
- Memory outputs are registered and change only on state transitions.

## Configuration
- LSU_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to REQ and on entry to WAIT, and increments each cycle in those states.
  - When the count reaches TIMEOUT_CYC, the FSM goes to DONE, o_timeout pulses and o_mem_req drops.
- LSU_TIMEOUT_EN undefined: no counter, REQ/WAIT wait indefinitely, o_timeout tied to 0 (port kept).

## Test plan
- SB x=0xA5, addr 0x1003, ack at cycle 1 → o_mem_addr 0x1000, bmask 1000, wdata 0xA5A5A5A5; stall high 2 cycles; no o_ld_vld.
- LB addr 0x2002, rdata 0x00800000, ack cycle 1, rvalid cycle 4 → o_ld_data 0xFFFFFF80 with o_ld_vld in cycle 5; LBU same → 0x00000080.
- LW addr 0x3002 → o_misalign pulse at cycle 1, o_mem_req never high, o_ld_data 0; funct3 011 at addr 0x3000 → same result.
- LHU addr 0x4002, ack delayed 3 cycles, rdata 0xBEEF1234 → req held stable 3 cycles, result 0x0000BEEF.
- Reset pulsed in WAIT, then rvalid → FSM in IDLE, no o_ld_vld, all outputs at reset values.
- With LSU_TIMEOUT_EN and TIMEOUT_CYC=4, ack never returned → o_timeout at cycle 5, o_mem_req low from cycle 5.
